// File: rtl/mold_feed_arb_pkg.sv
// Shared definitions for the mold feed path: default stream widths, timeout
// settings, arbiter FSM states and one-hot grant encodings.
package mold_feed_arb_pkg;

  localparam int AXI_DATA_W_DEF  = 64;
  localparam int AXI_KEEP_W_DEF  = 8;
  localparam int TIMEOUT_W_DEF   = 8;
  localparam int TIMEOUT_CYC_DEF = 200;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_A    = 2'b01;
  localparam logic [1:0] GRANT_B    = 2'b10;

endpackage

// File: rtl/mold_feed_arb_rr_arb2.sv
// Two-requester round-robin picker: combinational one-hot pick, plus a
// registered last-served pointer that advances only when a pick is taken.
module rr_arb2
  import mold_feed_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic [1:0] grant_o
);

  logic last_b_q;
  logic last_b_d;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_o = GRANT_NONE;
    case (req_i)
      2'b01:   grant_o = GRANT_A;
      2'b10:   grant_o = GRANT_B;
      2'b11:   grant_o = last_b_q ? GRANT_A : GRANT_B;
      default: grant_o = GRANT_NONE;
    endcase
  end

  always_comb begin
    last_b_d = last_b_q;
    if (take_i && (grant_o != GRANT_NONE)) begin
      last_b_d = grant_o[1];
    end
  end

  // Pointer starts at B so feed A wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: rtl/mold_feed_arb.sv
// Packet-granular arbiter merging two UDP payload feeds into a single stream
// toward the mold parser, with a stall timeout that aborts a stuck packet.
module mold_feed_arb
  import mold_feed_arb_pkg::*;
#(
  parameter int AXI_DATA_W  = AXI_DATA_W_DEF,
  parameter int AXI_KEEP_W  = AXI_KEEP_W_DEF,
  parameter int TIMEOUT_W   = TIMEOUT_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  a_axis_tvalid_i,
  input  logic [AXI_KEEP_W-1:0] a_axis_tkeep_i,
  input  logic [AXI_DATA_W-1:0] a_axis_tdata_i,
  input  logic                  a_axis_tlast_i,
  input  logic                  a_axis_tuser_i,
  output logic                  a_axis_tready_o,

  input  logic                  b_axis_tvalid_i,
  input  logic [AXI_KEEP_W-1:0] b_axis_tkeep_i,
  input  logic [AXI_DATA_W-1:0] b_axis_tdata_i,
  input  logic                  b_axis_tlast_i,
  input  logic                  b_axis_tuser_i,
  output logic                  b_axis_tready_o,

  output logic                  m_axis_tvalid_o,
  output logic [AXI_KEEP_W-1:0] m_axis_tkeep_o,
  output logic [AXI_DATA_W-1:0] m_axis_tdata_o,
  output logic                  m_axis_tlast_o,
  output logic                  m_axis_tuser_o,
  input  logic                  m_axis_tready_i,

  output logic [1:0]            grant_o,
  output logic                  abort_o,
  output logic [15:0]           pkt_cnt_a_o,
  output logic [15:0]           pkt_cnt_b_o
);

  // TIMEOUT_CYC must be below 2**TIMEOUT_W so the saturated count is representable.
  localparam logic [TIMEOUT_W-1:0] STALL_LIMIT = TIMEOUT_W'(TIMEOUT_CYC);
  localparam logic [TIMEOUT_W-1:0] STALL_LAST  = TIMEOUT_W'(TIMEOUT_CYC - 1);

  arb_state_e           state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic [TIMEOUT_W-1:0] stall_q, stall_d;
  logic                 abort_q, abort_d;
  logic [15:0]          pkt_cnt_a_q, pkt_cnt_a_d;
  logic [15:0]          pkt_cnt_b_q, pkt_cnt_b_d;

  logic [1:0]           pick;
  logic                 arb_take;
  logic                 beat_ok;
  logic                 last_ok;

  assign arb_take = (state_q == ST_IDLE) && (a_axis_tvalid_i || b_axis_tvalid_i);

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .req_i   ({b_axis_tvalid_i, a_axis_tvalid_i}),
    .take_i  (arb_take),
    .grant_o (pick)
  );

  // grant_q is zero whenever the FSM is idle, so the mux needs no state term.
  always_comb begin
    m_axis_tvalid_o = 1'b0;
    m_axis_tkeep_o  = '0;
    m_axis_tdata_o  = '0;
    m_axis_tlast_o  = 1'b0;
    m_axis_tuser_o  = 1'b0;
    if (grant_q[0]) begin
      m_axis_tvalid_o = a_axis_tvalid_i;
      m_axis_tkeep_o  = a_axis_tkeep_i;
      m_axis_tdata_o  = a_axis_tdata_i;
      m_axis_tlast_o  = a_axis_tlast_i;
      m_axis_tuser_o  = a_axis_tuser_i;
    end else if (grant_q[1]) begin
      m_axis_tvalid_o = b_axis_tvalid_i;
      m_axis_tkeep_o  = b_axis_tkeep_i;
      m_axis_tdata_o  = b_axis_tdata_i;
      m_axis_tlast_o  = b_axis_tlast_i;
      m_axis_tuser_o  = b_axis_tuser_i;
    end
  end

  assign a_axis_tready_o = grant_q[0] & m_axis_tready_i;
  assign b_axis_tready_o = grant_q[1] & m_axis_tready_i;

  assign beat_ok = m_axis_tvalid_o & m_axis_tready_i;
  assign last_ok = beat_ok & m_axis_tlast_o;

  // A completing beat is checked before the timeout so it always wins.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    stall_d     = stall_q;
    abort_d     = 1'b0;
    pkt_cnt_a_d = pkt_cnt_a_q;
    pkt_cnt_b_d = pkt_cnt_b_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_take) begin
          state_d = ST_BUSY;
          grant_d = pick;
          stall_d = '0;
        end
      end
      ST_BUSY: begin
        if (last_ok) begin
          state_d     = ST_IDLE;
          grant_d     = GRANT_NONE;
          stall_d     = '0;
          pkt_cnt_a_d = pkt_cnt_a_q + {15'd0, grant_q[0]};
          pkt_cnt_b_d = pkt_cnt_b_q + {15'd0, grant_q[1]};
        end else if (beat_ok) begin
          stall_d = '0;
        end else if (stall_q >= STALL_LAST) begin
          state_d = ST_IDLE;
          grant_d = GRANT_NONE;
          stall_d = STALL_LIMIT;
          abort_d = 1'b1;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = GRANT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= GRANT_NONE;
      stall_q     <= '0;
      abort_q     <= 1'b0;
      pkt_cnt_a_q <= '0;
      pkt_cnt_b_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      stall_q     <= stall_d;
      abort_q     <= abort_d;
      pkt_cnt_a_q <= pkt_cnt_a_d;
      pkt_cnt_b_q <= pkt_cnt_b_d;
    end
  end

  assign grant_o     = grant_q;
  assign abort_o     = abort_q;
  assign pkt_cnt_a_o = pkt_cnt_a_q;
  assign pkt_cnt_b_o = pkt_cnt_b_q;

endmodule

// File: doc/mold_feed_arb.md
MOLD_FEED_ARB -- requirements
Module: mold_feed_arb

Interface
REQ-001 SHALL expose parameters, one per line:
- AXI_DATA_W, 64, stream data width.
- AXI_KEEP_W, 8, byte-keep width.
- TIMEOUT_W, 8, stall-counter width.
- TIMEOUT_CYC, 200, idle cycles before abort.
REQ-002 SHALL expose ports, one per line:
- clk, in, 1, single clock.
- reset, in, 1, asynchronous active-high reset.
- a_axis_tvalid_i/tkeep_i/tdata_i/tlast_i/tuser_i, in, 1/KEEP/DATA/1/1, feed A UDP payload stream.
- a_axis_tready_o, out, 1, feed A ready.
- b_axis_* (same set as feed A), in/out, same widths, feed B.
- m_axis_tvalid_o/tkeep_o/tdata_o/tlast_o/tuser_o, out, 1/KEEP/DATA/1/1, stream to the mold parser.
- m_axis_tready_i, in, 1, parser ready.
- grant_o, out, 2, one-hot {B,A} current owner; 0 when idle.
- abort_o, out, 1, one-cycle pulse when a packet is aborted by timeout.
- pkt_cnt_a_o / pkt_cnt_b_o, out, 16, completed packets per feed.

Function
REQ-003 SHALL arbitrate at packet granularity: once granted, a feed owns the output until a beat with tlast is accepted (tvalid&tready&tlast) or until timeout.
REQ-004 SHALL implement FSM states IDLE, BUSY. IDLE->BUSY when any input tvalid=1. BUSY->IDLE on accepted tlast beat or on timeout. No other transitions.
REQ-005 SHALL register the grant, giving one bubble cycle: a tvalid first seen in IDLE is forwarded no earlier than the next cycle.
REQ-006 SHALL select round-robin in IDLE. If only one feed is valid, that feed wins. If both are valid, the feed not served last wins. last_q updates on every IDLE->BUSY.
REQ-007 SHALL pass m_axis_* combinationally from the granted feed in BUSY; m_axis_tvalid_o=0 in IDLE; data/keep/last/user are don't-care when tvalid=0.
REQ-008 SHALL drive granted tready_o = m_axis_tready_i; the non-granted tready_o=0; both tready_o=0 in IDLE.
REQ-009 SHALL count stall cycles in BUSY: the counter clears on every accepted beat and on entering BUSY, and increments otherwise. It saturates at TIMEOUT_CYC; TIMEOUT_CYC SHALL be < 2^TIMEOUT_W.
REQ-010 SHALL, when the counter reaches TIMEOUT_CYC, pulse abort_o for exactly one cycle, return to IDLE the next cycle, and leave the packet counter unchanged.
REQ-011 SHALL increment pkt_cnt_x by 1 per accepted tlast beat of feed x, with 16-bit modulo wrap (0xFFFF->0x0000).
REQ-012 SHALL give an accepted tlast beat priority over timeout in the same cycle: completion is counted and abort_o stays 0.
REQ-013 SHALL forward tkeep and tuser unmodified. No reordering, dropping, or merging of beats within a granted packet.
REQ-014 SHALL allow back-to-back packets from the same feed only via a new IDLE arbitration (one bubble cycle after each tlast).

Reset
REQ-015 SHALL, on reset assertion, immediately force: state=IDLE, grant_o=0, last_q=B (so A wins first tie), stall counter=0, pkt counters=0, abort_o=0, all tready_o=0, m_axis_tvalid_o=0.
REQ-016 SHALL abandon any in-flight packet on reset mid-packet, with no abort_o pulse. The first cycle after reset release is IDLE.

Structure
REQ-017 SHALL place the FSM state enum and the default TIMEOUT_CYC/AXI widths in the shared mold package used by the parser top.
REQ-018 SHALL instantiate one sub-module, rr_arb2: a 2-requester round-robin picker with last-served pointer, purely combinational pick plus registered pointer.
REQ-019 SHALL keep all other logic (mux, counters, FSM) flat in mold_feed_arb.

Verification
REQ-020 SHALL cover: A only, 3-beat packet, tready=1 -> grant_o=01 one cycle after first tvalid; 3 beats out in order; pkt_cnt_a_o=1; return to IDLE.
REQ-021 SHALL cover: A and B valid simultaneously after reset -> A served first, then B; grant_o sequence 01, 00, 10; pkt_cnt_a_o=pkt_cnt_b_o=1.
REQ-022 SHALL cover: B granted, then tready held 0 for 5 cycles mid-packet -> b_axis_tready_o=0 for those cycles, a_axis_tready_o=0 throughout, no data loss.
REQ-023 SHALL cover: A granted, tvalid dropped for 200 cycles (TIMEOUT_CYC=200) -> abort_o high exactly one cycle; pkt_cnt_a_o unchanged; IDLE next cycle.
REQ-024 SHALL cover: pkt_cnt_b_o preloaded at 0xFFFF via 65535 packets, then one more packet -> counter reads 0x0000.
REQ-025 SHALL cover: reset asserted on beat 2 of a 4-beat packet -> all outputs reach reset values asynchronously; no abort_o; a new packet after release is served normally.
